// File: rtl/sd_pkg.sv
// sd_pkg: shared state encoding and frame geometry for the SD command serializer.
package sd_pkg;
  typedef enum logic [2:0] {IDLE, DATA, CRC, STOP, GAP} sd_cmd_state_e;
  localparam int SD_CMD_FRAME_BITS   = 48;
  localparam int SD_CMD_CRC_BITS     = 7;
  localparam int SD_CMD_PAYLOAD_BITS = 40;
endpackage

// File: rtl/sd_cmd_tx_if.sv
// sd_cmd_tx_if: command request handshake (index + argument) into the serializer.
interface sd_cmd_tx_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [5:0]  CMD_INDEX;
  logic [31:0] CMD_ARG;
  modport master (output CMD_VALID, CMD_INDEX, CMD_ARG, input CMD_READY);
  modport slave  (input CMD_VALID, CMD_INDEX, CMD_ARG, output CMD_READY);
endinterface

// File: rtl/sd_crc_7.sv
// sd_crc_7: serial CRC7 (x^7+x^3+1), one message bit per enabled clock.
module sd_crc_7 (
  input  logic       BITVAL,
  input  logic       Enable,
  input  logic       CLK,
  input  logic       RST,
  output logic [6:0] CRC
);
  logic inv;
  assign inv = BITVAL ^ CRC[6];
  always_ff @(posedge CLK)
    if (RST) CRC <= '0;
    else if (Enable) CRC <= {CRC[5:3], CRC[2] ^ inv, CRC[1:0], inv};
endmodule

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: host-side SD CMD-line serializer; 40 payload bits feed sd_crc_7, then CRC and end bit.
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int NCC_MIN = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SD_CE,
  sd_cmd_tx_if.slave  cmd,
  output logic        CMD_OUT,
  output logic        CMD_OE,
  output logic        DONE
);
  sd_cmd_state_e state_q, state_d;
  logic [39:0]   shreg_q, shreg_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          crc_clear, crc_en;
  logic [6:0]    crc;

  sd_crc_7 u_crc (
    .BITVAL (shreg_q[39]),
    .Enable (crc_en),
    .CLK    (CLK),
    .RST    (RST | crc_clear),
    .CRC    (crc)
  );

  assign crc_en        = (state_q == DATA) & SD_CE;
  assign cmd.CMD_READY = ~RST & (state_q == IDLE);
  assign CMD_OE        = ~RST & (state_q inside {DATA, CRC, STOP});
  assign CMD_OUT       = RST | (state_q == DATA ? shreg_q[39] : state_q == CRC ? crc[cnt_q[2:0]] : 1'b1);
  assign DONE          = done_q;

  // One shared down-counter serves payload bits, CRC bits and the idle gap.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    crc_clear = 1'b0;
    case (state_q)
      IDLE: if (cmd.CMD_VALID & cmd.CMD_READY) begin
        crc_clear = 1'b1;
        shreg_d   = {2'b01, cmd.CMD_INDEX, cmd.CMD_ARG};
        cnt_d     = 8'(SD_CMD_PAYLOAD_BITS - 1);
        state_d   = DATA;
      end
      DATA: if (SD_CE) begin
        shreg_d = {shreg_q[38:0], 1'b0};
        cnt_d   = cnt_q == 8'd0 ? 8'(SD_CMD_CRC_BITS - 1) : cnt_q - 8'd1;
        state_d = cnt_q == 8'd0 ? CRC : DATA;
      end
      CRC: if (SD_CE) begin
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd0 ? STOP : CRC;
      end
      STOP: if (SD_CE) begin
        done_d  = 1'b1;
        cnt_d   = 8'(NCC_MIN - 1);
        state_d = GAP;
      end
      GAP: if (SD_CE) begin
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd0 ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb_sd_cmd_tx: directed frame, timing, gap and abort checks for sd_cmd_tx.
module tb_sd_cmd_tx;
  import sd_pkg::*;
  logic CLK = 1'b0, RST = 1'b1, SD_CE = 1'b0;
  logic CMD_OUT, CMD_OE, DONE;
  int tests = 0, fails = 0;
  logic [47:0] frame;
  int bits, done_at, oe_cyc, gap, dcount;

  sd_cmd_tx_if cmd();
  sd_cmd_tx #(.NCC_MIN(8)) dut (
    .CLK(CLK), .RST(RST), .SD_CE(SD_CE), .cmd(cmd),
    .CMD_OUT(CMD_OUT), .CMD_OE(CMD_OE), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input int per, input bit hold,
                           output logic [47:0] fr, output int nb, output int dat, output int oe);
    int n = 0;
    int c = 0;
    fr = '0; nb = 0; dat = -1; oe = 0;
    cmd.CMD_VALID = 1'b1; cmd.CMD_INDEX = idx; cmd.CMD_ARG = arg; SD_CE = 1'b1;
    while (!cmd.CMD_READY && n < 100) begin tick; n++; end
    tick;
    while (dat < 0 && c < 1000) begin
      cmd.CMD_VALID = hold;
      if (hold) begin cmd.CMD_INDEX = 6'($urandom); cmd.CMD_ARG = $urandom; end
      SD_CE = (c % per) == per - 1;
      if (SD_CE && CMD_OE) begin fr = {fr[46:0], CMD_OUT}; nb++; end
      if (CMD_OE) oe++;
      tick;
      c++;
      if (DONE) dat = c;
    end
    cmd.CMD_VALID = 1'b0;
    SD_CE = 1'b1;
  endtask

  task automatic wait_gap(output int n);
    n = 0;
    SD_CE = 1'b1;
    while (!cmd.CMD_READY && n < 100) begin
      tick;
      n++;
      if (n == 1) chk("done_one_pulse", 64'(DONE), 64'd0);
    end
  endtask

  initial begin
    cmd.CMD_VALID = 1'b0; cmd.CMD_INDEX = '0; cmd.CMD_ARG = '0;
    repeat (3) tick;
    chk("rst_ready", 64'(cmd.CMD_READY), 64'd0);
    chk("rst_oe", 64'(CMD_OE), 64'd0);
    chk("rst_out", 64'(CMD_OUT), 64'd1);
    chk("rst_done", 64'(DONE), 64'd0);
    RST = 1'b0;
    tick;
    chk("idle_ready", 64'(cmd.CMD_READY), 64'd1);
    chk("idle_oe", 64'(CMD_OE), 64'd0);

    run_frame(6'd0, 32'h0, 1, 1'b0, frame, bits, done_at, oe_cyc);
    chk("cmd0_frame", 64'(frame), 64'h400000000095);
    chk("cmd0_bits", 64'(bits), 64'(SD_CMD_FRAME_BITS));
    chk("cmd0_done_at", 64'(done_at), 64'd48);
    chk("cmd0_oe_cycles", 64'(oe_cyc), 64'd48);
    chk("cmd0_done_oe", 64'(CMD_OE), 64'd0);
    chk("cmd0_done_ready", 64'(cmd.CMD_READY), 64'd0);
    wait_gap(gap);
    chk("gap1", 64'(gap), 64'd8);

    run_frame(6'd8, 32'h000001AA, 1, 1'b0, frame, bits, done_at, oe_cyc);
    chk("cmd8_frame", 64'(frame), 64'h48000001AA87);
    chk("cmd8_done_at", 64'(done_at), 64'd48);
    wait_gap(gap);
    chk("gap2", 64'(gap), 64'd8);

    run_frame(6'd17, 32'h0, 1, 1'b1, frame, bits, done_at, oe_cyc);
    chk("cmd17_hold_frame", 64'(frame), 64'h510000000055);
    chk("cmd17_done_at", 64'(done_at), 64'd48);
    wait_gap(gap);
    chk("gap3", 64'(gap), 64'd8);

    run_frame(6'd0, 32'h0, 4, 1'b0, frame, bits, done_at, oe_cyc);
    chk("ce4_frame", 64'(frame), 64'h400000000095);
    chk("ce4_bits", 64'(bits), 64'd48);
    chk("ce4_done_at", 64'(done_at), 64'd192);
    chk("ce4_oe_cycles", 64'(oe_cyc), 64'd192);
    wait_gap(gap);
    chk("gap4", 64'(gap), 64'd8);

    cmd.CMD_VALID = 1'b1; cmd.CMD_INDEX = 6'd0; cmd.CMD_ARG = 32'h0; SD_CE = 1'b1;
    tick;
    cmd.CMD_VALID = 1'b0;
    repeat (20) tick;
    chk("mid_oe", 64'(CMD_OE), 64'd1);
    RST = 1'b1;
    tick;
    chk("abort_oe", 64'(CMD_OE), 64'd0);
    chk("abort_out", 64'(CMD_OUT), 64'd1);
    chk("abort_ready", 64'(cmd.CMD_READY), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    RST = 1'b0;
    dcount = 0;
    repeat (60) begin tick; if (DONE) dcount++; end
    chk("abort_no_done", 64'(dcount), 64'd0);
    chk("abort_ready_after", 64'(cmd.CMD_READY), 64'd1);
    run_frame(6'd0, 32'h0, 1, 1'b0, frame, bits, done_at, oe_cyc);
    chk("post_abort_frame", 64'(frame), 64'h400000000095);
    chk("post_abort_done_at", 64'(done_at), 64'd48);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
Host-side SD command-line serializer. Accepts a 6-bit command index and a 32-bit argument over a valid/ready handshake. Emits the 48-bit SD command frame on the CMD line, one bit per SD_CE tick. The block sits directly upstream of sd_crc_7: it drives BITVAL/Enable for the first 40 frame bits, then shifts out the resulting 7-bit CRC.

Parameters:
NCC_MIN, 8, minimum SD_CE ticks of idle CMD line (CMD_OUT=1, CMD_OE=0) after the end bit before CMD_READY reasserts; legal range 1..255

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
SD_CE  input  1  SD clock-enable tick; one frame bit advances per cycle with SD_CE=1
CMD_VALID  input  1  command request
CMD_READY  output  1  block can accept a command
CMD_INDEX  input  6  command index, sampled on handshake
CMD_ARG  input  32  command argument, sampled on handshake
CMD_OUT  output  1  serial CMD line data, MSB first
CMD_OE  output  1  CMD line output enable
DONE  output  1  one-CLK pulse after the end bit has been sent

Behaviour:
- Frame, MSB first: start 0, transmission 1, CMD_INDEX[5:0], CMD_ARG[31:0], CRC[6:0], end 1. Total 48 bits. CRC7 (x^7+x^3+1, init 0) covers the first 40 bits.
- Reset, and every cycle with RST=1: state IDLE, CMD_OUT=1, CMD_OE=0, CMD_READY=0, DONE=0, counters 0, sd_crc_7 cleared. RST mid-frame aborts the frame immediately; the line returns to idle on the next cycle.
- States: IDLE, DATA, CRC, STOP, GAP.
- IDLE
  - CMD_READY=1; CMD_OE=0; CMD_OUT=1.
  - On CMD_VALID&CMD_READY: load the 40-bit shift register {0,1,INDEX,ARG}, assert RST into sd_crc_7 for that cycle, set the bit counter to 39, and go to DATA.
  - SD_CE in the accept cycle is ignored.
- DATA
  - CMD_OE=1; CMD_OUT=shreg[39].
  - On an SD_CE cycle: drive BITVAL=shreg[39] and Enable=1 into sd_crc_7, shift left, decrement the counter.
  - At counter 0 with SD_CE: go to CRC, counter=6.
  - Enable=0 whenever SD_CE=0 or the state is not DATA.
- CRC
  - CMD_OE=1; CMD_OUT=CRC[counter], taken from sd_crc_7 (stable, since Enable=0).
  - On SD_CE: decrement.
  - At 0 with SD_CE: go to STOP.
- STOP
  - CMD_OE=1; CMD_OUT=1.
  - On SD_CE: DONE=1 for one CLK; go to GAP with the gap counter = NCC_MIN-1.
- GAP
  - CMD_OE=0; CMD_OUT=1; CMD_READY=0.
  - On SD_CE: decrement.
  - At 0 with SD_CE: go to IDLE.
- Frame time: exactly 48 SD_CE ticks from the first tick after accept through the end-bit tick. Ticks need not be consecutive; with SD_CE held at 1, DONE asserts 48 CLK after the accept edge.
- CMD_VALID outside IDLE is ignored; there is no queuing. INDEX/ARG changes after the handshake have no effect.
- Back-to-back commands: with SD_CE=1, CMD_READY returns exactly NCC_MIN cycles after DONE.

Decomposition:
- Shared package sd_pkg: state enum (IDLE, DATA, CRC, STOP, GAP) and constants SD_CMD_FRAME_BITS=48, SD_CMD_CRC_BITS=7, SD_CMD_PAYLOAD_BITS=40.
- One sub-module: instantiate the existing sd_crc_7 (BITVAL, Enable, CLK, RST, CRC[6:0]).
  - Drive its RST with RST | crc_clear.
  - CRC generation is not duplicated in this block.

Test Plan:
- SD_CE=1, CMD0 arg 0x00000000 -> serial frame 0x400000000095 (CRC 0x4A), CMD_OE high for exactly 48 cycles, DONE 48 cycles after accept.
- CMD8 arg 0x000001AA -> frame 0x48000001AA87 (CRC 0x43). CMD17 arg 0 -> 0x510000000055 (CRC 0x2A).
- SD_CE pulsing every 4th cycle, CMD0 -> same 48 bits, each held 4 CLK; DONE at the 48th tick only.
- Two commands back-to-back with NCC_MIN=8, SD_CE=1 -> CMD_READY low for exactly 8 cycles after DONE; second frame correct (CRC restarts from 0).
- RST pulsed at bit 20 of a frame -> next cycle CMD_OE=0, CMD_OUT=1, no DONE. A following CMD0 produces 0x400000000095.
- CMD_VALID held high during DATA with changing INDEX/ARG -> ignored; the in-flight frame is unchanged.
